// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
// Combinational helpers only; no latency or backpressure of its own.
package fifo_pkg;

   localparam int WIDTH_DEF     = 8;
   localparam int DEPTH_DEF     = 16;
   localparam int RATIO_DEF     = 2;
   localparam int FLUSH_CYC_DEF = 16;

   typedef enum logic [1:0] {
      FL_IDLE  = 2'd0,
      FL_PEND  = 2'd1,
      FL_FLUSH = 2'd2
   } flush_st_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Low n bits set; callers cast the result down to their lane count.
   function automatic logic [31:0] keep_mask(input int n);
      return (32'd1 << n) - 32'd1;
   endfunction

endpackage

// File: rtl/pkr_skid_q2.sv
// Two-entry FIFO-ordered valid/ready queue; head is registered so out_dat is stable under stall.
// Latency 1 cycle push-to-valid; push and pop in the same cycle are both honoured.
module pkr_skid_q2 #(
   parameter int W = 18
) (
   input  logic         rd_clk,
   input  logic         rst,
   input  logic         in_vld,
   input  logic [W-1:0] in_dat,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [W-1:0] out_dat,
   output logic [1:0]   count
);

   logic [W-1:0] e0;
   logic [W-1:0] e1;
   logic         pop;

   assign out_vld = (count != 2'd0);
   assign out_dat = e0;
   assign pop     = out_vld && out_rdy;

   always_ff @(posedge rd_clk or negedge rst) begin
      if (!rst) begin
         e0    <= '0;
         e1    <= '0;
         count <= 2'd0;
      end else begin
         case ({in_vld, pop})
            2'b10: begin
               if (count == 2'd0) e0 <= in_dat;
               else               e1 <= in_dat;
               count <= count + 2'd1;
            end
            2'b01: begin
               e0    <= e1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  e0 <= in_dat;
               end else begin
                  e0 <= e1;
                  e1 <= in_dat;
               end
            end
            default: ;
         endcase
      end
   end

   // The upstream credit check keeps occupancy low enough that this never fires.
   a_no_push_full: assert property (@(posedge rd_clk) disable iff (!rst)
                                    !(in_vld && count == 2'd2));

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops FIFO entries, packs RATIO of them per word, flushes partial words on idle or request.
// First word RATIO+1 cycles after first pop; pops stop once queue+assembly hold 2*RATIO entries.
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int RATIO     = RATIO_DEF,
   parameter int FLUSH_CYC = FLUSH_CYC_DEF
) (
   input  logic                   rd_clk,
   input  logic                   rst,
   input  logic                   fifo_empty,
   input  logic [WIDTH-1:0]       fifo_rd_data,
   input  logic                   fifo_error,
   output logic                   fifo_rd_en,
   output logic [WIDTH*RATIO-1:0] m_data,
   output logic [RATIO-1:0]       m_keep,
   output logic                   m_valid,
   input  logic                   m_ready,
   input  logic                   flush_req,
   input  logic                   err_clr,
   output logic                   err_sticky
);

   localparam int DW       = WIDTH * RATIO;
   localparam int QW       = DW + RATIO;
   localparam int CW       = (clog2(RATIO + 1) < 1) ? 1 : clog2(RATIO + 1);
   localparam int OW       = clog2(2 * RATIO + 2) + 1;
   localparam int IW       = (clog2(FLUSH_CYC + 1) < 1) ? 1 : clog2(FLUSH_CYC + 1);
   localparam int IDLE_MAX = (FLUSH_CYC > 0) ? FLUSH_CYC - 1 : 0;

   logic [CW-1:0]    cnt;
   logic             inflight;
   logic [DW-1:0]    asm_dat;
   logic [DW-1:0]    asm_nxt;
   logic [IW-1:0]    idle_cnt;
   logic [1:0]       qwords;
   logic [OW-1:0]    occ;
   logic             word_done;
   logic             eligible;
   logic             idle_hit;
   logic             req_now;
   logic             flush_go;
   logic             push_vld;
   logic [RATIO-1:0] push_keep;
   logic [QW-1:0]    push_dat;
   logic [QW-1:0]    q_dat;
   flush_st_t        fl_st;
   flush_st_t        fl_nxt;

   // Every entry already committed (queued words, assembled lanes, pop in flight) uses a credit.
   assign occ        = OW'(RATIO) * OW'(qwords) + OW'(cnt) + OW'(inflight);
   assign fifo_rd_en = rst && !fifo_empty && (occ < OW'(2 * RATIO));

   assign word_done = inflight && (cnt == CW'(RATIO - 1));
   assign eligible  = (cnt != '0) && !inflight;
   assign idle_hit  = (FLUSH_CYC != 0) && eligible && (idle_cnt == IW'(IDLE_MAX));

   always_comb begin
      asm_nxt = asm_dat;
      if (inflight) asm_nxt[int'(cnt)*WIDTH +: WIDTH] = fifo_rd_data;
   end

   always_comb begin
      push_vld  = word_done || flush_go;
      push_keep = word_done ? {RATIO{1'b1}} : RATIO'(keep_mask(int'(cnt)));
      push_dat  = {push_keep, asm_nxt};
   end

   // Flush requests wait in PEND for the capture to settle, in FLUSH for a queue slot.
   always_comb begin
      fl_nxt   = fl_st;
      flush_go = 1'b0;
      req_now  = (fl_st != FL_IDLE) || flush_req || idle_hit;
      if (req_now) begin
         if (eligible && qwords < 2'd2) begin
            flush_go = 1'b1;
            fl_nxt   = FL_IDLE;
         end else if (eligible) begin
            fl_nxt = FL_FLUSH;
         end else if (cnt == '0 && !inflight) begin
            fl_nxt = FL_IDLE;
         end else begin
            fl_nxt = FL_PEND;
         end
      end
   end

   always_ff @(posedge rd_clk or negedge rst) begin
      if (!rst) fl_st <= FL_IDLE;
      else      fl_st <= fl_nxt;
   end

   // Assembly is zeroed after each push so a flushed partial word has clean unused lanes.
   always_ff @(posedge rd_clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         inflight <= 1'b0;
         asm_dat  <= '0;
         idle_cnt <= '0;
      end else begin
         inflight <= fifo_rd_en;
         if (push_vld) begin
            cnt     <= '0;
            asm_dat <= '0;
         end else begin
            asm_dat <= asm_nxt;
            if (inflight) cnt <= cnt + 1'b1;
         end
         if (fifo_empty && cnt != '0 && !inflight) begin
            if (idle_cnt != IW'(IDLE_MAX)) idle_cnt <= idle_cnt + 1'b1;
         end else begin
            idle_cnt <= '0;
         end
      end
   end

   always_ff @(posedge rd_clk or negedge rst) begin
      if (!rst)            err_sticky <= 1'b0;
      else if (err_clr)    err_sticky <= 1'b0;
      else if (fifo_error) err_sticky <= 1'b1;
   end

   pkr_skid_q2 #(
      .W(QW)
   ) u_q (
      .rd_clk (rd_clk),
      .rst    (rst),
      .in_vld (push_vld),
      .in_dat (push_dat),
      .out_vld(m_valid),
      .out_rdy(m_ready),
      .out_dat(q_dat),
      .count  (qwords)
   );

   assign m_data = q_dat[DW-1:0];
   assign m_keep = q_dat[QW-1:DW];

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a behavioural FIFO read side and output capture queue.
module tb_fifo_rd_packer;

   logic        rd_clk = 1'b0;
   logic        rst = 1'b0;
   logic        fifo_empty = 1'b1;
   logic [7:0]  fifo_rd_data = 8'h00;
   logic        fifo_error = 1'b0;
   logic        fifo_rd_en;
   logic [15:0] m_data;
   logic [1:0]  m_keep;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic        flush_req = 1'b0;
   logic        err_clr = 1'b0;
   logic        err_sticky;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]  fq[$];
   logic [17:0] oq[$];
   logic        en_s = 1'b0;

   always #5 rd_clk = ~rd_clk;

   fifo_rd_packer #(.WIDTH(8), .RATIO(2), .FLUSH_CYC(16)) dut (
      .rd_clk      (rd_clk),
      .rst         (rst),
      .fifo_empty  (fifo_empty),
      .fifo_rd_data(fifo_rd_data),
      .fifo_error  (fifo_error),
      .fifo_rd_en  (fifo_rd_en),
      .m_data      (m_data),
      .m_keep      (m_keep),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .flush_req   (flush_req),
      .err_clr     (err_clr),
      .err_sticky  (err_sticky)
   );

   // FIFO read side: data appears the cycle after an accepted pop.
   always @(negedge rd_clk) begin
      en_s = fifo_rd_en;
      if (fifo_rd_en && fifo_empty) begin
         miscompares++;
         $display("FAIL pop_while_empty: fifo_rd_en=1 with fifo_empty=1 at %0t", $time);
      end
      if (m_valid && m_ready) oq.push_back({m_keep, m_data});
   end

   always @(posedge rd_clk) begin
      #1;
      if (en_s && fq.size() > 0) fifo_rd_data = fq.pop_front();
      fifo_empty = (fq.size() == 0);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge rd_clk);
         #2;
      end
   endtask

   task automatic push(input logic [7:0] v);
      fq.push_back(v);
      fifo_empty = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      push(8'h99);
      m_ready = 1'b1;
      step(2);
      vectors++; if (fifo_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
      vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", m_valid); end
      vectors++; if (m_data !== 16'h0000) begin miscompares++; $display("FAIL reset_data: got %h want 0000", m_data); end
      vectors++; if (m_keep !== 2'b00) begin miscompares++; $display("FAIL reset_keep: got %b want 00", m_keep); end
      vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err_sticky); end
      fq.delete();
      fifo_empty = 1'b1;
      rst = 1'b1;
      step(1);
      oq.delete();
   endtask

   task automatic test_basic();
      int n_en, first_en, last_en, first_v;
      logic [17:0] got;
      n_en = 0; first_en = -1; last_en = -1; first_v = -1;
      m_ready = 1'b1;
      oq.delete();
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      for (int i = 0; i < 16; i++) begin
         @(negedge rd_clk);
         if (fifo_rd_en) begin
            if (first_en < 0) first_en = i;
            last_en = i;
            n_en++;
         end
         if (m_valid && first_v < 0) first_v = i;
      end
      vectors++; if (n_en !== 4) begin miscompares++; $display("FAIL basic_pops: got %0d want 4", n_en); end
      vectors++; if (last_en - first_en !== 3) begin miscompares++; $display("FAIL basic_pop_run: got span %0d want 3", last_en - first_en); end
      vectors++; if (first_v - first_en !== 3) begin miscompares++; $display("FAIL basic_latency: got %0d want 3", first_v - first_en); end
      vectors++; if (oq.size() !== 2) begin miscompares++; $display("FAIL basic_count: got %0d want 2", oq.size()); end
      got = (oq.size() > 0) ? oq[0] : 18'hx;
      vectors++; if (got !== 18'h32211) begin miscompares++; $display("FAIL basic_word0: got %h want 32211", got); end
      got = (oq.size() > 1) ? oq[1] : 18'hx;
      vectors++; if (got !== 18'h34433) begin miscompares++; $display("FAIL basic_word1: got %h want 34433", got); end
   endtask

   task automatic test_backpressure();
      int n_en;
      logic [17:0] exp_w [4];
      logic [17:0] got;
      exp_w = '{18'h30201, 18'h30403, 18'h30605, 18'h30807};
      n_en = 0;
      m_ready = 1'b0;
      step(1);
      oq.delete();
      for (int k = 1; k <= 8; k++) push(8'(k));
      for (int i = 0; i < 12; i++) begin
         @(negedge rd_clk);
         if (fifo_rd_en) n_en++;
      end
      vectors++; if (n_en !== 4) begin miscompares++; $display("FAIL bp_pops: got %0d want 4", n_en); end
      vectors++; if (fifo_rd_en !== 1'b0) begin miscompares++; $display("FAIL bp_rd_en_stop: got %b want 0", fifo_rd_en); end
      vectors++; if (m_valid !== 1'b1 || m_data !== 16'h0201) begin miscompares++; $display("FAIL bp_head: got v=%b %h want v=1 0201", m_valid, m_data); end
      vectors++; if (fq.size() !== 4) begin miscompares++; $display("FAIL bp_fifo_left: got %0d want 4", fq.size()); end
      step(1);
      m_ready = 1'b1;
      for (int i = 0; i < 40 && oq.size() < 4; i++) @(negedge rd_clk);
      step(6);
      vectors++; if (oq.size() !== 4) begin miscompares++; $display("FAIL bp_count: got %0d want 4", oq.size()); end
      for (int k = 0; k < 4; k++) begin
         got = (oq.size() > k) ? oq[k] : 18'hx;
         vectors++; if (got !== exp_w[k]) begin miscompares++; $display("FAIL bp_word%0d: got %h want %h", k, got, exp_w[k]); end
      end
   endtask

   task automatic test_idle_flush();
      int first_en, first_v;
      logic [17:0] got;
      first_en = -1; first_v = -1;
      m_ready = 1'b1;
      oq.delete();
      push(8'hA5);
      for (int i = 0; i < 40 && first_v < 0; i++) begin
         @(negedge rd_clk);
         if (fifo_rd_en && first_en < 0) first_en = i;
         if (m_valid) first_v = i;
      end
      vectors++; if (first_v - first_en !== 18) begin miscompares++; $display("FAIL idle_latency: got %0d want 18", first_v - first_en); end
      step(2);
      got = (oq.size() > 0) ? oq[0] : 18'hx;
      vectors++; if (got !== 18'h100A5) begin miscompares++; $display("FAIL idle_word: got %h want 100a5", got); end
      vectors++; if (oq.size() !== 1) begin miscompares++; $display("FAIL idle_count: got %0d want 1", oq.size()); end
   endtask

   task automatic test_flush_req();
      m_ready = 1'b0;
      oq.delete();
      push(8'h5A);
      step(2);
      flush_req = 1'b1;
      step(1);
      flush_req = 1'b0;
      vectors++; if (m_valid !== 1'b1 || m_data !== 16'h005A || m_keep !== 2'b01) begin miscompares++; $display("FAIL freq_word: got v=%b %h k=%b want v=1 005a k=01", m_valid, m_data, m_keep); end
      m_ready = 1'b1; step(1); m_ready = 1'b0;
      // request while the pop is still in flight is held until the capture lands
      push(8'h77);
      step(1);
      flush_req = 1'b1;
      step(1);
      flush_req = 1'b0;
      step(1);
      vectors++; if (m_valid !== 1'b1 || m_data !== 16'h0077 || m_keep !== 2'b01) begin miscompares++; $display("FAIL freq_pend: got v=%b %h k=%b want v=1 0077 k=01", m_valid, m_data, m_keep); end
      m_ready = 1'b1; step(1); m_ready = 1'b0;
      step(2);
      flush_req = 1'b1;
      step(1);
      flush_req = 1'b0;
      step(3);
      vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL freq_drop: got v=%b want 0", m_valid); end
      push(8'h66);
      step(4);
      vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL freq_no_stale: got v=%b want 0", m_valid); end
      push(8'h67);
      step(2);
      vectors++; if (m_valid !== 1'b1 || m_data !== 16'h6766 || m_keep !== 2'b11) begin miscompares++; $display("FAIL freq_full: got v=%b %h k=%b want v=1 6766 k=11", m_valid, m_data, m_keep); end
      m_ready = 1'b1; step(1); m_ready = 1'b0;
      vectors++; if (oq.size() !== 3) begin miscompares++; $display("FAIL freq_count: got %0d want 3", oq.size()); end
   endtask

   task automatic test_error();
      fifo_error = 1'b1;
      step(1);
      fifo_error = 1'b0;
      vectors++; if (err_sticky !== 1'b1) begin miscompares++; $display("FAIL err_set: got %b want 1", err_sticky); end
      step(3);
      vectors++; if (err_sticky !== 1'b1) begin miscompares++; $display("FAIL err_hold: got %b want 1", err_sticky); end
      fifo_error = 1'b1;
      err_clr = 1'b1;
      step(1);
      fifo_error = 1'b0;
      err_clr = 1'b0;
      vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL err_clr_prio: got %b want 0", err_sticky); end
      step(2);
      vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL err_stay_clr: got %b want 0", err_sticky); end
   endtask

   task automatic test_reset_mid();
      logic [17:0] got;
      m_ready = 1'b0;
      oq.delete();
      push(8'h31); push(8'h32); push(8'h33);
      step(3);
      vectors++; if (m_valid !== 1'b1 || m_data !== 16'h3231) begin miscompares++; $display("FAIL rmid_pre: got v=%b %h want v=1 3231", m_valid, m_data); end
      rst = 1'b0;
      #1;
      vectors++; if (m_valid !== 1'b0 || m_keep !== 2'b00) begin miscompares++; $display("FAIL rmid_async: got v=%b k=%b want v=0 k=00", m_valid, m_keep); end
      step(2);
      rst = 1'b1;
      step(2);
      vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_quiet: got v=%b want 0", m_valid); end
      m_ready = 1'b1;
      push(8'hC1); push(8'hC2);
      for (int i = 0; i < 20 && oq.size() < 1; i++) @(negedge rd_clk);
      step(4);
      got = (oq.size() > 0) ? oq[0] : 18'hx;
      vectors++; if (got !== 18'h3C2C1) begin miscompares++; $display("FAIL rmid_word: got %h want 3c2c1", got); end
      vectors++; if (oq.size() !== 1) begin miscompares++; $display("FAIL rmid_count: got %0d want 1", oq.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_idle_flush();
      test_flush_req();
      test_error();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
      $fatal(1);
   end

endmodule
